// File: rtl/debugger_pkg.sv
// Shared definitions for the debugger host-command receiver: opcodes, FSM encoding, payload length.
package debugger_pkg;

    localparam logic [7:0] OP_STEP   = 8'h01;
    localparam logic [7:0] OP_RUN    = 8'h02;
    localparam logic [7:0] OP_HALT   = 8'h03;
    localparam logic [7:0] OP_DUMP   = 8'h04;
    localparam logic [7:0] OP_BP_SET = 8'h05;
    localparam logic [7:0] OP_BP_CLR = 8'h06;

    localparam int PAYLOAD_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b >= OP_STEP) && (b <= OP_BP_CLR);
    endfunction

endpackage

// File: rtl/debugger_rx_timer.sv
// Inter-byte timeout counter: clears on every byte, saturates at TIMEOUT_CYCLES,
// and raises `expired` while at the limit unless suppressed by clear or saturate.
module debugger_rx_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic saturate,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + W'(1);
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = (cnt == LIMIT) && !clear && !saturate;

endmodule

// File: rtl/debugger_rx.sv
// Host-command receiver for the MIPS debug unit: parses UART bytes into command strobes
// and a breakpoint register. Define DEBUGGER_RX_CHECKSUM_EN to require a trailing XOR byte.
module debugger_rx
    import debugger_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  r_data,
    output logic        cmd_step,
    output logic        cmd_run,
    output logic        cmd_halt,
    output logic        cmd_dump,
    output logic [31:0] bp_addr,
    output logic        bp_valid,
    output logic        rx_err,
    output logic        busy
);

`ifdef DEBUGGER_RX_CHECKSUM_EN
    localparam int STAGE_W = 32;
    logic [7:0] xor_acc;
    logic [7:0] op_q;
`else
    // The fourth payload byte commits directly from r_data, so only three bytes are held.
    localparam int STAGE_W = 24;
`endif

    state_t               state, state_next;
    logic [STAGE_W-1:0]   stage;
    logic [1:0]           byte_cnt;
    logic                 last_payload;
    logic                 expired;
    logic                 exec;
    logic [7:0]           exec_code;
    logic                 err_d;
    logic [31:0]          commit_addr;

    debugger_rx_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (rx_done_tick),
        .saturate (state == ST_IDLE),
        .expired  (expired)
    );

    assign last_payload = (byte_cnt == 2'(PAYLOAD_LEN - 1));
    assign busy         = (state != ST_IDLE);

`ifdef DEBUGGER_RX_CHECKSUM_EN
    assign commit_addr = stage;
`else
    assign commit_addr = {stage, r_data};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (r_data == OP_BP_SET) begin
                        state_next = ST_PAYLOAD;
`ifdef DEBUGGER_RX_CHECKSUM_EN
                    end else if (is_opcode(r_data)) begin
                        state_next = ST_CHECK;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (last_payload) begin
`ifdef DEBUGGER_RX_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_IDLE;
`endif
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (expired) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        exec      = 1'b0;
        exec_code = r_data;
        err_d     = 1'b0;
        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!is_opcode(r_data)) begin
                        err_d = 1'b1;
`ifndef DEBUGGER_RX_CHECKSUM_EN
                    end else if (r_data != OP_BP_SET) begin
                        exec = 1'b1;
`endif
                    end
                end
                ST_PAYLOAD: begin
`ifndef DEBUGGER_RX_CHECKSUM_EN
                    exec      = last_payload;
                    exec_code = OP_BP_SET;
`endif
                end
`ifdef DEBUGGER_RX_CHECKSUM_EN
                ST_CHECK: begin
                    if (r_data == xor_acc) begin
                        exec      = 1'b1;
                        exec_code = op_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end else if (expired) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_step <= 1'b0;
            cmd_run  <= 1'b0;
            cmd_halt <= 1'b0;
            cmd_dump <= 1'b0;
            rx_err   <= 1'b0;
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            stage    <= '0;
            byte_cnt <= '0;
`ifdef DEBUGGER_RX_CHECKSUM_EN
            xor_acc  <= '0;
            op_q     <= '0;
`endif
        end else begin
            cmd_step <= exec && (exec_code == OP_STEP);
            cmd_run  <= exec && (exec_code == OP_RUN);
            cmd_halt <= exec && (exec_code == OP_HALT);
            cmd_dump <= exec && (exec_code == OP_DUMP);
            rx_err   <= err_d;

            if (exec && (exec_code == OP_BP_SET)) begin
                bp_addr  <= commit_addr;
                bp_valid <= 1'b1;
            end else if (exec && (exec_code == OP_BP_CLR)) begin
                bp_valid <= 1'b0;
            end

            if (rx_done_tick) begin
                if (state == ST_IDLE) begin
                    byte_cnt <= '0;
`ifdef DEBUGGER_RX_CHECKSUM_EN
                    xor_acc  <= r_data;
                    op_q     <= r_data;
`endif
                end else if (state == ST_PAYLOAD) begin
                    stage    <= {stage[STAGE_W-9:0], r_data};
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef DEBUGGER_RX_CHECKSUM_EN
                    xor_acc  <= xor_acc ^ r_data;
`endif
                end
            end else if (expired) begin
                stage <= '0;
            end
        end
    end

endmodule

// File: tb/tb_debugger_rx.sv
// Scoreboard bench for debugger_rx: stimulus pushes expected output events,
// a monitor pops and compares whenever a strobe fires or the breakpoint changes.
module tb_debugger_rx;

    localparam int unsigned TO = 40;

    typedef struct {
        logic [4:0]  strobes;   // {rx_err, dump, halt, run, step}
        logic        bp_valid;
        logic [31:0] bp_addr;
        int          cyc;       // required observation cycle, 0 = not checked
    } ev_t;

    localparam logic [4:0] S_STEP = 5'b00001;
    localparam logic [4:0] S_RUN  = 5'b00010;
    localparam logic [4:0] S_HALT = 5'b00100;
    localparam logic [4:0] S_DUMP = 5'b01000;
    localparam logic [4:0] S_ERR  = 5'b10000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        cmd_step, cmd_run, cmd_halt, cmd_dump, bp_valid, rx_err, busy;
    logic [31:0] bp_addr;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_tick = 0;
    logic mon_en = 1'b0;
    ev_t  sb [$];

    logic        m_valid;
    logic [31:0] m_addr;

    debugger_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .r_data       (r_data),
        .cmd_step     (cmd_step),
        .cmd_run      (cmd_run),
        .cmd_halt     (cmd_halt),
        .cmd_dump     (cmd_dump),
        .bp_addr      (bp_addr),
        .bp_valid     (bp_valid),
        .rx_err       (rx_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [4:0] s, input logic v, input logic [31:0] a, input int c);
        ev_t e;
        e.strobes = s; e.bp_valid = v; e.bp_addr = a; e.cyc = c;
        return e;
    endfunction

    // Sends n bytes (first byte in bits [39:32]) on consecutive cycles, optionally appending
    // the XOR trailer when the checksum build is in use; the expected event is pushed before
    // the final tick and is timed to the cycle after it.
    task automatic send_cmd(input int n, input logic [39:0] bytes, input logic ck,
                            input logic exp_en, input logic [4:0] s,
                            input logic v, input logic [31:0] a);
        logic [7:0] x;
        logic [7:0] b;
        int total;
        x = 8'h00;
        total = n;
`ifdef DEBUGGER_RX_CHECKSUM_EN
        if (ck) total = n + 1;
`endif
        for (int i = 0; i < total; i++) begin
            if (i < n) b = bytes[39 - 8*i -: 8];
            else       b = x;
            x = x ^ b;
            @(negedge clk);
            if (exp_en && (i == total - 1)) sb.push_back(mk(s, v, a, cyc + 1));
            rx_done_tick = 1'b1;
            r_data       = b;
            last_tick    = cyc + 1;
        end
        @(negedge clk);
        rx_done_tick = 1'b0;
        r_data       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle with a strobe or a breakpoint change is one output event.
    initial begin
        logic [4:0] s;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                s = {rx_err, cmd_dump, cmd_halt, cmd_run, cmd_step};
                if (s != 5'b0 || bp_valid !== m_valid || bp_addr !== m_addr) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event: got strobes=%b bp_valid=%b bp_addr=0x%08h at cyc %0d, want none",
                                 s, bp_valid, bp_addr, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (s !== e.strobes || bp_valid !== e.bp_valid || bp_addr !== e.bp_addr ||
                            (e.cyc != 0 && e.cyc != cyc)) begin
                            n_err++;
                            $display("FAIL event: got strobes=%b bp_valid=%b bp_addr=0x%08h cyc=%0d, want strobes=%b bp_valid=%b bp_addr=0x%08h cyc=%0d",
                                     s, bp_valid, bp_addr, cyc, e.strobes, e.bp_valid, e.bp_addr, e.cyc);
                        end
                    end
                end
            end
            m_valid = bp_valid;
            m_addr  = bp_addr;
        end
    end

    initial begin
        reset = 1'b0;
        idle(3);
        check("reset_strobes", {27'b0, rx_err, cmd_dump, cmd_halt, cmd_run, cmd_step}, 32'h0);
        check("reset_bp_addr", bp_addr, 32'h0);
        check("reset_bp_valid", {31'b0, bp_valid}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset  = 1'b1;
        idle(1);
        mon_en = 1'b1;
        idle(1);

        // Single-byte step
        send_cmd(1, {8'h01, 32'h0}, 1'b1, 1'b1, S_STEP, 1'b0, 32'h0);
        idle(3);

        // Breakpoint set, then clear keeps the address
        send_cmd(5, 40'h05_BFC0_0040, 1'b1, 1'b1, 5'b0, 1'b1, 32'hBFC0_0040);
        idle(3);
        send_cmd(1, {8'h06, 32'h0}, 1'b1, 1'b1, 5'b0, 1'b0, 32'hBFC0_0040);
        idle(3);

        // Unknown opcodes, including both edges of the valid range
        send_cmd(1, {8'h7F, 32'h0}, 1'b0, 1'b1, S_ERR, 1'b0, 32'hBFC0_0040);
        check("busy_after_bad_op", {31'b0, busy}, 32'h0);
        idle(2);
        send_cmd(1, {8'h00, 32'h0}, 1'b0, 1'b1, S_ERR, 1'b0, 32'hBFC0_0040);
        idle(2);
        send_cmd(1, {8'h07, 32'h0}, 1'b0, 1'b1, S_ERR, 1'b0, 32'hBFC0_0040);
        idle(2);

        // Stalled payload times out, then a dump still works
        send_cmd(2, {16'h0512, 24'h0}, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);
        check("busy_mid_payload", {31'b0, busy}, 32'h1);
        sb.push_back(mk(S_ERR, 1'b0, 32'hBFC0_0040, last_tick + TO + 1));
        idle(TO + 5);
        check("busy_after_timeout", {31'b0, busy}, 32'h0);
        send_cmd(1, {8'h04, 32'h0}, 1'b1, 1'b1, S_DUMP, 1'b0, 32'hBFC0_0040);
        idle(3);

`ifdef DEBUGGER_RX_CHECKSUM_EN
        // Wrong trailer discards, right trailer runs
        send_cmd(2, {16'h0203, 24'h0}, 1'b0, 1'b1, S_ERR, 1'b0, 32'hBFC0_0040);
        idle(3);
        send_cmd(1, {8'h02, 32'h0}, 1'b1, 1'b1, S_RUN, 1'b0, 32'hBFC0_0040);
        idle(3);
`else
        send_cmd(1, {8'h02, 32'h0}, 1'b1, 1'b1, S_RUN, 1'b0, 32'hBFC0_0040);
        idle(3);
`endif

        // Re-arm a breakpoint, then reset mid-command drops the partial and clears it
        send_cmd(5, 40'h05_0102_0304, 1'b1, 1'b1, 5'b0, 1'b1, 32'h0102_0304);
        idle(3);
        send_cmd(2, {16'h05AA, 24'h0}, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);
        sb.push_back(mk(5'b0, 1'b0, 32'h0, 0));
        reset = 1'b0;
        idle(3);
        check("busy_in_reset", {31'b0, busy}, 32'h0);
        reset = 1'b1;
        idle(2);
        send_cmd(1, {8'h03, 32'h0}, 1'b1, 1'b1, S_HALT, 1'b0, 32'h0);
        idle(5);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
